// File: rtl/ssp_pkg.sv
// Shared constants for the SSP transmit FIFO.
// Default widths, depth, watermark and pointer-width helpers.
package ssp_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 8;
  localparam int WMARK_DEF  = DEPTH_DEF / 2;
  localparam int PTR_W_DEF  = $clog2(DEPTH_DEF) + 1;

  // Extra MSB distinguishes full from empty.
  function automatic int ptr_w(input int depth);
    return $clog2(depth) + 1;
  endfunction

  function automatic int wmark_def(input int depth);
    return depth / 2;
  endfunction

endpackage

// File: rtl/ssp_fifo_ram.sv
// Register-array storage for the SSP transmit FIFO.
// One synchronous write port, one combinational read port.
module ssp_fifo_ram
  import ssp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF
) (
  input  logic                       PCLK,
  input  logic                       we,
  input  logic [$clog2(DEPTH)-1:0]   waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [$clog2(DEPTH)-1:0]   raddr,
  output logic [DATA_W-1:0]          rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge PCLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ssp_tx_fifo_p.sv
// SSP transmit FIFO: pointers, flags, watermark interrupt.
// Optional sticky OVERRUN flag under SSP_TXFIFO_OVERRUN_EN.
module ssp_tx_fifo_p
  import ssp_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int DEPTH  = DEPTH_DEF,
  parameter int WMARK  = wmark_def(DEPTH)
) (
  input  logic                     PCLK,
  input  logic                     CLEAR_B,
  input  logic                     PSEL,
  input  logic                     PWRITE,
  input  logic [DATA_W-1:0]        IN_DATA,
  input  logic                     READ,
  output logic [DATA_W-1:0]        OUT_DATA,
  output logic                     READY,
  output logic                     FULL,
  output logic [$clog2(DEPTH):0]   LEVEL,
  output logic                     SSPTXINTR
`ifdef SSP_TXFIFO_OVERRUN_EN
  ,
  output logic                     OVERRUN
`endif
);

  localparam int PW = ptr_w(DEPTH);
  localparam int AW = PW - 1;

  logic [PW-1:0] wrptr;
  logic [PW-1:0] rdptr;
  logic          push_req;
  logic          push;
  logic          pop;

  assign push_req = PSEL & PWRITE;
  assign push     = push_req & ~FULL;
  assign pop      = READ & READY;

  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B) begin
      wrptr <= '0;
      rdptr <= '0;
    end else begin
      if (push) wrptr <= wrptr + 1'b1;
      if (pop)  rdptr <= rdptr + 1'b1;
    end
  end

  assign READY = (wrptr != rdptr);
  assign FULL  = (wrptr[PW-1] != rdptr[PW-1]) &&
                 (wrptr[AW-1:0] == rdptr[AW-1:0]);
  assign LEVEL = wrptr - rdptr;
  assign SSPTXINTR = (LEVEL <= PW'(WMARK));

`ifdef SSP_TXFIFO_OVERRUN_EN
  // Sticky until reset; software must clear the block to acknowledge.
  always_ff @(posedge PCLK or negedge CLEAR_B) begin
    if (!CLEAR_B)           OVERRUN <= 1'b0;
    else if (push_req & FULL) OVERRUN <= 1'b1;
  end
`endif

  ssp_fifo_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_ram (
    .PCLK  (PCLK),
    .we    (push),
    .waddr (wrptr[AW-1:0]),
    .wdata (IN_DATA),
    .raddr (rdptr[AW-1:0]),
    .rdata (OUT_DATA)
  );

endmodule

// File: tb/tb_ssp_tx_fifo_p.sv
// Directed scoreboard bench for ssp_tx_fifo_p (DEPTH=8, WMARK=4).
// Honours SSP_TXFIFO_OVERRUN_EN when defined.
module tb_ssp_tx_fifo_p;

  localparam int DW = 8;
  localparam int DP = 8;
  localparam int WM = 4;

  logic          PCLK = 1'b0;
  logic          CLEAR_B;
  logic          PSEL;
  logic          PWRITE;
  logic [DW-1:0] IN_DATA;
  logic          READ;
  logic [DW-1:0] OUT_DATA;
  logic          READY;
  logic          FULL;
  logic [3:0]    LEVEL;
  logic          SSPTXINTR;
`ifdef SSP_TXFIFO_OVERRUN_EN
  logic          OVERRUN;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [DW-1:0] sb[$];
  bit   m_ovr = 1'b0;

  always #5 PCLK = ~PCLK;

  ssp_tx_fifo_p #(.DATA_W(DW), .DEPTH(DP), .WMARK(WM)) dut (
    .PCLK      (PCLK),
    .CLEAR_B   (CLEAR_B),
    .PSEL      (PSEL),
    .PWRITE    (PWRITE),
    .IN_DATA   (IN_DATA),
    .READ      (READ),
    .OUT_DATA  (OUT_DATA),
    .READY     (READY),
    .FULL      (FULL),
    .LEVEL     (LEVEL),
    .SSPTXINTR (SSPTXINTR)
`ifdef SSP_TXFIFO_OVERRUN_EN
    ,
    .OVERRUN   (OVERRUN)
`endif
  );

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_flags(input string tag);
    int lvl;
    lvl = sb.size();
    chk({tag, ".level"}, 32'(LEVEL), lvl);
    chk({tag, ".ready"}, 32'(READY), 32'(lvl > 0));
    chk({tag, ".full"},  32'(FULL),  32'(lvl == DP));
    chk({tag, ".intr"},  32'(SSPTXINTR), 32'(lvl <= WM));
`ifdef SSP_TXFIFO_OVERRUN_EN
    chk({tag, ".ovr"},   32'(OVERRUN), 32'(m_ovr));
`endif
  endtask

  // One clock: drive, check head word on pop, clock, update model, check flags.
  task automatic cyc(input string tag, input bit wr, input bit sel,
                     input logic [DW-1:0] d, input bit rd);
    bit acc_push;
    bit acc_pop;
    acc_push = wr && sel && (sb.size() < DP);
    acc_pop  = rd && (sb.size() > 0);
    PSEL = sel; PWRITE = wr; IN_DATA = d; READ = rd;
    #1;
    if (acc_pop) chk({tag, ".out"}, 32'(OUT_DATA), 32'(sb[0]));
    @(posedge PCLK);
    #1;
    PSEL = 1'b0; PWRITE = 1'b0; READ = 1'b0; IN_DATA = '0;
    if (wr && sel && !acc_push) m_ovr = 1'b1;
    if (acc_pop)  void'(sb.pop_front());
    if (acc_push) sb.push_back(d);
    chk_flags(tag);
  endtask

  task automatic push(input logic [DW-1:0] d);
    cyc("push", 1'b1, 1'b1, d, 1'b0);
  endtask

  task automatic pop();
    cyc("pop", 1'b0, 1'b0, '0, 1'b1);
  endtask

  initial begin
    CLEAR_B = 1'b0; PSEL = 1'b0; PWRITE = 1'b0; READ = 1'b0; IN_DATA = '0;
    #3;
    chk_flags("rst");
    repeat (2) @(posedge PCLK);
    #1 CLEAR_B = 1'b1;
    chk_flags("post_rst");

    // Mid-stream asynchronous clear with 3 words queued
    push(8'hA1); push(8'hA2); push(8'hA3);
    #2 CLEAR_B = 1'b0;
    #1;
    sb.delete();
    m_ovr = 1'b0;
    chk_flags("async_clr");
    @(posedge PCLK);
    #1 CLEAR_B = 1'b1;

    // Fill to full, then a dropped ninth push
    for (int i = 1; i <= 8; i++) push(8'(i));
    cyc("push_full", 1'b1, 1'b1, 8'hFF, 1'b0);

    // Drain; final pop on empty is ignored
    for (int i = 0; i < 8; i++) pop();
    cyc("pop_empty", 1'b0, 1'b0, '0, 1'b1);

    // Strobes without their qualifier must not push
    cyc("pwrite_only", 1'b1, 1'b0, 8'h33, 1'b0);
    cyc("psel_only",   1'b0, 1'b1, 8'h44, 1'b0);

    // Wrap the index
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    for (int i = 0; i < 5; i++) pop();
    for (int i = 0; i < 6; i++) push(8'h20 + 8'(i));
    chk("wrap.level6", 32'(LEVEL), 32'd6);
    for (int i = 0; i < 6; i++) pop();

    // Simultaneous push+pop at level 3 and at full
    for (int i = 0; i < 3; i++) push(8'h30 + 8'(i));
    cyc("pp_lvl3", 1'b1, 1'b1, 8'h3F, 1'b1);
    chk("pp_lvl3.level", 32'(LEVEL), 32'd3);
    while (sb.size() < DP) push(8'h40 + 8'(sb.size()));
    cyc("pp_full", 1'b1, 1'b1, 8'hEE, 1'b1);
    chk("pp_full.level", 32'(LEVEL), 32'd7);
    while (sb.size() > 0) pop();

    // Watermark boundary both ways
    for (int i = 0; i < 4; i++) push(8'h50 + 8'(i));
    chk("wm4.intr", 32'(SSPTXINTR), 32'd1);
    push(8'h54);
    chk("wm5.intr", 32'(SSPTXINTR), 32'd0);
    pop();
    chk("wm4b.intr", 32'(SSPTXINTR), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
